// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline stage boundaries: FSM state encoding, per-boundary
// bundle widths and packed bundle layouts.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } pipe_state_t;

    localparam int unsigned MEMWB_CTRL_W = 2;
    localparam int unsigned MEMWB_DATA_W = 69;
    localparam int unsigned EXMEM_CTRL_W = 3;
    localparam int unsigned EXMEM_DATA_W = 69;
    localparam int unsigned IDEX_CTRL_W  = 8;
    localparam int unsigned IDEX_DATA_W  = 106;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } memwb_ctrl_t;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] aluout;
        logic [4:0]  writereg;
    } memwb_data_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } exmem_ctrl_t;

    typedef struct packed {
        logic [31:0] aluout;
        logic [31:0] writedata;
        logic [4:0]  writereg;
    } exmem_data_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic [2:0] alucontrol;
        logic       alusrc;
        logic       regdst;
    } idex_ctrl_t;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] signimm;
    } idex_data_t;

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: valid/ready handshake, main + skid slot, flush to bubble,
// optional masking of the control bundle while no entry is presented.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W              = MEMWB_CTRL_W,
    parameter int unsigned DATA_W              = MEMWB_DATA_W,
    parameter bit          ZERO_CTRL_ON_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    pipe_state_t       state_q, state_d;
    logic              in_ready_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid_in;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    // State, handshake and slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            if (load_main_in) begin
                main_ctrl_q <= in_ctrl;
                main_data_q <= in_data;
            end else if (load_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
                main_data_q <= skid_data_q;
            end
            if (load_skid_in) begin
                skid_ctrl_q <= in_ctrl;
                skid_data_q <= in_data;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d      = TWO;
                        load_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Main slot retains its contents on drain/flush; the bubble mask hides stale control.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q == ONE) || (state_q == TWO);
        out_data  = main_data_q;
        out_ctrl  = main_ctrl_q;
        if (ZERO_CTRL_ON_BUBBLE && !out_valid) begin
            out_ctrl = '0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: two instances (bubble masking on/off) share stimulus.
module tb_pipe_stage_elastic;

    localparam int unsigned CW = 2;
    localparam int unsigned DW = 69;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic          nz_in_ready, nz_out_valid;
    logic [CW-1:0] nz_out_ctrl;
    logic [DW-1:0] nz_out_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .CTRL_W              (CW),
        .DATA_W              (DW),
        .ZERO_CTRL_ON_BUBBLE (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
    );

    pipe_stage_elastic #(
        .CTRL_W              (CW),
        .DATA_W              (DW),
        .ZERO_CTRL_ON_BUBBLE (1'b0)
    ) dut_nz (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (nz_in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (nz_out_valid),
        .out_ready (out_ready),
        .out_ctrl  (nz_out_ctrl),
        .out_data  (nz_out_data)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    // Load 0x11 then 0x22 (ctrl 2'b11) under a stall, leaving the stage in TWO.
    task automatic fill_two();
        out_ready = 1'b0;
        push(2'b11, 69'h11);
        tick();
        push(2'b11, 69'h22);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b11;
        in_data   = 69'h5a;
        out_ready = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_data", out_data, 0);
        check("rst_ready", in_ready, 1);
        check("rst_nz_ctrl", nz_out_ctrl, 0);

        // Streaming, one transfer per cycle.
        for (int i = 1; i <= 4; i++) begin
            push(2'b01, DW'(i));
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, i);
            check("stream_ctrl", out_ctrl, 2'b01);
            check("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_ctrl_masked", out_ctrl, 0);
        check("drain_ctrl_nz", nz_out_ctrl, 2'b01);
        check("drain_data_hold", out_data, 4);

        // Stall into skid, then release.
        out_ready = 1'b0;
        push(2'b11, 69'h11);
        tick();
        check("stall_a_data", out_data, 69'h11);
        check("stall_a_ready", in_ready, 1);
        push(2'b11, 69'h22);
        tick();
        check("stall_two_ready", in_ready, 0);
        check("stall_two_data", out_data, 69'h11);
        in_valid = 1'b0;
        tick();
        check("stall_hold_data", out_data, 69'h11);
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("release_b_data", out_data, 69'h22);
        check("release_b_valid", out_valid, 1);
        check("release_ready", in_ready, 1);
        tick();
        check("release_empty", out_valid, 0);

        // Flush while holding two entries.
        fill_two();
        check("pre_flush_ready", in_ready, 0);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        check("flush_valid", out_valid, 0);
        check("flush_ctrl", out_ctrl, 0);
        check("flush_ready", in_ready, 1);
        check("flush_data_hold", out_data, 69'h11);
        check("flush_nz_ctrl", nz_out_ctrl, 2'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_b", out_valid, 0);
        end

        // Flush with concurrent input drops the input.
        push(2'b11, 69'h33);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_in_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_in_data", out_data, 69'h11);
        tick();
        check("flush_in_empty", out_valid, 0);

        // Reset mid-stall in TWO; input during reset discarded.
        fill_two();
        reset = 1'b1;
        push(2'b10, 69'h55);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_ctrl", out_ctrl, 0);
        check("midrst_data", out_data, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_nz_ctrl", nz_out_ctrl, 0);
        out_ready = 1'b1;
        push(2'b01, 69'h44);
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 69'h44);

        // Bubble masking after drain to EMPTY.
        push(2'b11, 69'h66);
        tick();
        in_valid = 1'b0;
        check("bub_ctrl_live", out_ctrl, 2'b11);
        tick();
        check("bub_valid", out_valid, 0);
        check("bub_ctrl_masked", out_ctrl, 2'b00);
        check("bub_ctrl_nz", nz_out_ctrl, 2'b11);
        check("bub_nz_valid", nz_out_valid, 0);

        // Simultaneous flush and reset from TWO.
        fill_two();
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        check("fr_valid", out_valid, 0);
        check("fr_data", out_data, 0);
        check("fr_ready", in_ready, 1);
        check("fr_nz_ctrl", nz_out_ctrl, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Generic, parametrised pipeline stage register; successor to the fixed per-stage registers between IF/ID/EX/MEM/WB.
- Carries a control bundle plus a data bundle with a valid/ready handshake and a 2-entry skid buffer.
- Adds flush (bubble insertion) and stall propagation, so the hazard unit can stall or kill any stage boundary.
- Default widths match the MEM->WB boundary: ctrl = {regwrite, memtoreg}; data = {rd[31:0], aluout[31:0], writereg[4:0]}.

Parameters:
- CTRL_W, 2, control bundle width.
- DATA_W, 69, data bundle width.
- ZERO_CTRL_ON_BUBBLE, 1, when 1, out_ctrl is forced to all-zero whenever out_valid=0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill all held entries at the next edge.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream entry present; registered.
- out_ready  in  1  downstream accepts; 0 = stall.
- out_ctrl  out  CTRL_W  registered control bundle.
- out_data  out  DATA_W  registered data bundle.

Behaviour:
- Clock/reset: single clock clk; reset synchronous, active-high.
- Reset values:
  - out_valid=0, out_ctrl=0, out_data=0, in_ready=1, state=EMPTY, skid contents=0.
  - Inputs presented in a reset cycle are discarded.
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty or streaming. Full throughput, one transfer per cycle, when out_ready is held at 1.
- States: EMPTY (main and skid free), ONE (main full), TWO (main and skid full).
- Transitions (no flush):
  - EMPTY: in_fire -> ONE, main<=in. Otherwise stay.
  - ONE, in_fire & out_fire: stay ONE, main<=in.
  - ONE, in_fire & !out_fire: -> TWO, skid<=in, main held.
  - ONE, !in_fire & out_fire: -> EMPTY.
  - ONE, neither: hold.
  - TWO: in_ready=0, so no in_fire is possible. out_fire -> ONE, main<=skid. Otherwise hold.
- in_ready is registered: it is 1 in the cycle after any state other than TWO is entered.
- Ordering: strict FIFO order is preserved; the skid entry is always younger than the main entry.
- Main-register outputs:
  - out_valid=1 in ONE and TWO.
  - out_ctrl/out_data are stable while out_valid & !out_ready (stall hold).
- Flush:
  - Highest priority after reset: next state EMPTY, out_valid<=0, in_ready<=1.
  - Any in_fire or out_fire in the flush cycle is ignored for state purposes. The downstream consumer still samples the current output that cycle.
  - out_ctrl<=0 when ZERO_CTRL_ON_BUBBLE=1. out_data holds its last value.
- Bubble: when ZERO_CTRL_ON_BUBBLE=1, out_ctrl is 0 in every cycle with out_valid=0, including after drain to EMPTY. No write-enable may leak.
- Reset asserted mid-stall in TWO: both entries are lost, and the outputs return to their reset values next cycle.
- Simultaneous flush & reset: reset wins; the result is identical.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_t.
  - localparams for the per-boundary widths: MEMWB_CTRL_W=2, MEMWB_DATA_W=69, EXMEM_*, IDEX_*.
  - Packed struct typedefs for each boundary's ctrl/data bundles.
- No sub-module required.
  - Main and skid slots are two registers in one always_ff.
  - State update and in_ready are registered in the same block.

Test Plan:
- Streaming: reset, then in_valid=1 with in_data=1,2,3,4 on consecutive cycles and out_ready=1 -> out_data=1,2,3,4 one cycle later; in_ready stays 1.
- Stall into skid: send A=0x11, B=0x22 while out_ready=0 from the cycle A appears -> state TWO, in_ready=0 on the next cycle, out_data=0x11 held. Raise out_ready -> 0x11 then 0x22 appear, and in_ready returns to 1.
- Flush in TWO: hold entries 0x11/0x22 with in_ctrl=2'b11, assert flush for 1 cycle -> next cycle out_valid=0, out_ctrl=2'b00, in_ready=1; no 0x22 appears later.
- Flush with concurrent input: flush=1 and in_valid=1 with data 0x33 in the same cycle -> 0x33 dropped, stage EMPTY.
- Reset mid-operation: reach TWO, pulse reset -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1. The first post-reset input 0x44 emerges after 1 cycle.
- Bubble masking with ZERO_CTRL_ON_BUBBLE=0: drain to EMPTY -> out_ctrl retains its last value (2'b11) with out_valid=0. With parameter =1 the same sequence gives out_ctrl=2'b00.
